core_easy_ps_bridge: RTL and testbench

PS-facing initiator that drives `core_easy_hw_block`: accepts operands from the PS command side over a valid/ready handshake, presents each operand on the core's `in_num_ddr` with a one-cycle `start` pulse, and collects the core's `sum` into a result FIFO for the PS to read back. It sits between the PS register/AXI-lite glue and the core, on the same clock. It also reports busy, transaction-count and protocol-error status.

---
 rtl/core_easy_pkg.sv | 16 +
 rtl/easy_sync_fifo.sv | 63 ++++++
 rtl/core_easy_ps_bridge.sv | 100 ++++++++++
 tb/tb_core_easy_ps_bridge.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_easy_pkg.sv
// Shared definitions for the core_easy PS bridge: FSM encoding and default widths.
package core_easy_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    WAIT  = ST_WAIT
  } state_e;

endpackage

// File: rtl/easy_sync_fifo.sv
// First-word fall-through synchronous FIFO with occupancy count; head reads 0 when empty.
module easy_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       valid,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  // Pops on empty are dropped; a push when full is only allowed alongside a pop.
  always_comb begin
    do_pop  = pop & (count_q != '0);
    do_push = push & ((count_q != CW'(DEPTH)) | do_pop);
    valid   = (count_q != '0);
    full    = (count_q == CW'(DEPTH));
    count   = count_q;
    rd_data = valid ? mem[rd_ptr] : '0;
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/core_easy_ps_bridge.sv
// PS-side initiator for core_easy_hw_block: issues one operand per start pulse and
// queues the core's results for read-back, with busy/count/error status.
module core_easy_ps_bridge
  import core_easy_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  input  logic [DATA_WIDTH-1:0]         cmd_data,
  output logic                          cmd_ready,
  input  logic                          core_ready,
  input  logic                          core_send_data,
  input  logic [DATA_WIDTH-1:0]         core_sum,
  output logic                          core_start,
  output logic [DATA_WIDTH-1:0]         core_num_ddr,
  input  logic                          res_rd,
  output logic [DATA_WIDTH-1:0]         res_data,
  output logic                          res_valid,
  output logic [$clog2(FIFO_DEPTH):0]   res_count,
  output logic                          busy,
  output logic [CNT_WIDTH-1:0]          txn_count,
  output logic                          err_spurious
);

  state_e state_q;
  state_e state_d;
  logic   accept;
  logic   res_push;
  logic   fifo_full;

  // Next state, acceptance and result push decode.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    res_push  = 1'b0;
    cmd_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = core_ready & ~fifo_full & ~rst;
        if (cmd_valid & cmd_ready) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (core_send_data) begin
          res_push = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Start pulse and busy are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      core_start   <= 1'b0;
      busy         <= 1'b0;
      core_num_ddr <= '0;
      txn_count    <= '0;
      err_spurious <= 1'b0;
    end else begin
      state_q    <= state_d;
      core_start <= (state_d == ISSUE);
      busy       <= (state_d != IDLE);
      if (accept) begin
        core_num_ddr <= cmd_data;
      end
      if (res_push) begin
        txn_count <= txn_count + CNT_WIDTH'(1);
      end
      if (core_send_data && (state_q != WAIT)) begin
        err_spurious <= 1'b1;
      end
    end
  end

  easy_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (res_push),
    .push_data (core_sum),
    .pop       (res_rd),
    .rd_data   (res_data),
    .valid     (res_valid),
    .full      (fifo_full),
    .count     (res_count)
  );

endmodule

// File: tb/tb_core_easy_ps_bridge.sv
// Directed self-checking bench for core_easy_ps_bridge; the bench plays the core itself.
module tb_core_easy_ps_bridge;

  localparam int unsigned DW = 8;
  localparam int unsigned FD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic [DW-1:0] cmd_data;
  logic          cmd_ready;
  logic          core_ready;
  logic          core_send_data;
  logic [DW-1:0] core_sum;
  logic          core_start;
  logic [DW-1:0] core_num_ddr;
  logic          res_rd;
  logic [DW-1:0] res_data;
  logic          res_valid;
  logic [2:0]    res_count;
  logic          busy;
  logic [15:0]   txn_count;
  logic          err_spurious;

  // Narrow-counter copy sharing all inputs, used to observe counter wrap.
  logic          w_cmd_ready;
  logic          w_core_start;
  logic [DW-1:0] w_core_num_ddr;
  logic [DW-1:0] w_res_data;
  logic          w_res_valid;
  logic [2:0]    w_res_count;
  logic          w_busy;
  logic [3:0]    w_txn_count;
  logic          w_err_spurious;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_txn = 0;

  always #5 clk = ~clk;

  core_easy_ps_bridge #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .core_ready(core_ready), .core_send_data(core_send_data), .core_sum(core_sum),
    .core_start(core_start), .core_num_ddr(core_num_ddr), .res_rd(res_rd),
    .res_data(res_data), .res_valid(res_valid), .res_count(res_count), .busy(busy),
    .txn_count(txn_count), .err_spurious(err_spurious)
  );

  core_easy_ps_bridge #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .CNT_WIDTH(4)) dut_w (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(w_cmd_ready),
    .core_ready(core_ready), .core_send_data(core_send_data), .core_sum(core_sum),
    .core_start(w_core_start), .core_num_ddr(w_core_num_ddr), .res_rd(res_rd),
    .res_data(w_res_data), .res_valid(w_res_valid), .res_count(w_res_count), .busy(w_busy),
    .txn_count(w_txn_count), .err_spurious(w_err_spurious)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction: present operand, wait (bounded) for accept, answer with sum.
  task automatic do_txn(input logic [DW-1:0] op, input logic [DW-1:0] sum, input bit pop_in_wait);
    int waited = 0;
    cmd_valid  = 1'b1;
    cmd_data   = op;
    core_ready = 1'b1;
    #1;
    while (!cmd_ready && waited < 20) begin
      tick();
      waited++;
    end
    check("accept", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    check("start_pulse", 32'(core_start), 32'd1);
    check("num_ddr", 32'(core_num_ddr), 32'(op));
    check("busy_issue", 32'(busy), 32'd1);
    tick();
    check("start_low", 32'(core_start), 32'd0);
    check("num_ddr_hold", 32'(core_num_ddr), 32'(op));
    core_send_data = 1'b1;
    core_sum       = sum;
    res_rd         = pop_in_wait;
    tick();
    core_send_data = 1'b0;
    res_rd         = 1'b0;
    exp_txn++;
    check("busy_done", 32'(busy), 32'd0);
    check("txn_count", 32'(txn_count), 32'(exp_txn & 32'hFFFF));
  endtask

  task automatic pop_expect(input string tag, input logic [DW-1:0] exp);
    check(tag, 32'(res_data), 32'(exp));
    check("pop_valid", 32'(res_valid), 32'd1);
    res_rd = 1'b1;
    tick();
    res_rd = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b1; cmd_data = 8'hAA; core_ready = 1'b1;
    core_send_data = 1'b0; core_sum = '0; res_rd = 1'b0;
    tick();
    tick();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_start", 32'(core_start), 32'd0);
    check("rst_num_ddr", 32'(core_num_ddr), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_count", 32'(res_count), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_txn", 32'(txn_count), 32'd0);
    check("rst_err", 32'(err_spurious), 32'd0);
    cmd_valid = 1'b0;
    rst = 1'b0;
    tick();

    // core_ready low blocks acceptance with cmd_valid held
    core_ready = 1'b0; cmd_valid = 1'b1; cmd_data = 8'h12;
    #1;
    check("nr_cmd_ready", 32'(cmd_ready), 32'd0);
    tick();
    tick();
    check("nr_busy", 32'(busy), 32'd0);
    do_txn(8'h12, 8'h35, 1'b0);
    check("t1_res_data", 32'(res_data), 32'h35);
    check("t1_res_valid", 32'(res_valid), 32'd1);
    check("t1_res_count", 32'(res_count), 32'd1);
    pop_expect("t1_pop", 8'h35);
    check("t1_empty", 32'(res_count), 32'd0);

    // fill to depth, then a held fifth command waits for a pop
    for (int i = 1; i <= 4; i++) do_txn(8'(i), 8'(8'h80 + i), 1'b0);
    cmd_valid = 1'b1; cmd_data = 8'h05;
    #1;
    check("full_count", 32'(res_count), 32'd4);
    check("full_cmd_ready", 32'(cmd_ready), 32'd0);
    tick();
    check("full_busy", 32'(busy), 32'd0);
    check("full_head", 32'(res_data), 32'h81);
    res_rd = 1'b1;
    #1;
    check("full_pop_ready", 32'(cmd_ready), 32'd0);
    tick();
    res_rd = 1'b0;
    #1;
    check("after_pop_count", 32'(res_count), 32'd3);
    check("after_pop_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    check("fifth_start", 32'(core_start), 32'd1);
    check("fifth_num", 32'(core_num_ddr), 32'h05);
    tick();
    core_send_data = 1'b1; core_sum = 8'h85;
    tick();
    core_send_data = 1'b0;
    exp_txn++;
    check("fifth_count", 32'(res_count), 32'd4);
    pop_expect("ord2", 8'h82);
    pop_expect("ord3", 8'h83);
    pop_expect("ord4", 8'h84);
    pop_expect("ord5", 8'h85);
    check("drained", 32'(res_count), 32'd0);

    // simultaneous push and pop at count 2
    do_txn(8'h31, 8'hA0, 1'b0);
    do_txn(8'h32, 8'hA1, 1'b0);
    check("pp_pre", 32'(res_count), 32'd2);
    do_txn(8'h33, 8'hA2, 1'b1);
    check("pp_count", 32'(res_count), 32'd2);
    pop_expect("pp_head1", 8'hA1);
    pop_expect("pp_head2", 8'hA2);

    // spurious result strobe while idle
    core_send_data = 1'b1; core_sum = 8'h99;
    tick();
    core_send_data = 1'b0;
    check("sp_err", 32'(err_spurious), 32'd1);
    check("sp_count", 32'(res_count), 32'd0);
    check("sp_txn", 32'(txn_count), 32'(exp_txn));
    tick();
    check("sp_sticky", 32'(err_spurious), 32'd1);

    // pop on empty is ignored
    res_rd = 1'b1;
    tick();
    res_rd = 1'b0;
    check("ee_count", 32'(res_count), 32'd0);
    check("ee_valid", 32'(res_valid), 32'd0);
    check("ee_data", 32'(res_data), 32'd0);
    do_txn(8'h07, 8'h0E, 1'b0);
    pop_expect("ee_after", 8'h0E);

    // reset while waiting on the core
    cmd_valid = 1'b1; cmd_data = 8'h44;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("rw_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_txn = 0;
    check("rw_busy", 32'(busy), 32'd0);
    check("rw_start", 32'(core_start), 32'd0);
    check("rw_num", 32'(core_num_ddr), 32'd0);
    check("rw_count", 32'(res_count), 32'd0);
    check("rw_txn", 32'(txn_count), 32'd0);
    check("rw_err", 32'(err_spurious), 32'd0);
    core_send_data = 1'b1; core_sum = 8'h55;
    tick();
    core_send_data = 1'b0;
    check("rw_late_count", 32'(res_count), 32'd0);
    check("rw_late_txn", 32'(txn_count), 32'd0);
    check("rw_late_err", 32'(err_spurious), 32'd1);

    // counter wrap on the narrow copy: 15 -> 0 after one more transaction
    for (int i = 0; i < 16; i++) begin
      do_txn(8'(i), 8'(i + 1), 1'b0);
      pop_expect("wr_data", 8'(i + 1));
      if (i == 14) check("wrap_max", 32'(w_txn_count), 32'hF);
    end
    check("wrap_zero", 32'(w_txn_count), 32'h0);
    check("wrap_wide", 32'(txn_count), 32'd16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
